arbitro_rr: RTL and testbench
=============================

Name: arbitro_rr

Overview:
- Parametrised N-channel arbiter between N input FIFOs and N output FIFOs.
- Each cycle it pops at most one non-empty input FIFO whose destination output FIFO is not almost full.
- It forwards the word and pushes it into the output FIFO selected by the word's destination field.
- Supports fixed-priority and round-robin selection, per-destination backpressure, an enable gate and a grant counter; sits between the demux stage and the output FIFO bank.

Parameters:
- N_CH, 4, number of input and output channels (power of two, 2..16).
- DATA_W, 12, word width, including the destination field.
- DEST_W, $clog2(N_CH), localparam; destination field width = data[DATA_W-1 -: DEST_W].
- CNT_W, 16, width of the grant counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- active  in  1  arbitration enable; 0 = no new grants.
- rr_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- empty_in  in  N_CH  empty flags of the input FIFOs.
- data_in  in  N_CH*DATA_W  head words of the first-word-fall-through input FIFOs; channel i = data_in[i*DATA_W +: DATA_W].
- almost_full_out  in  N_CH  almost-full flags of the output FIFOs.
- pop  out  N_CH  one-hot-or-zero pop to the input FIFOs; combinational.
- push  out  N_CH  one-hot-or-zero push to the output FIFOs; registered.
- data_out  out  DATA_W  word that accompanies push; registered.
- grant_idx  out  DEST_W  index of the last granted input; registered.
- grant_cnt  out  CNT_W  total grants since reset; registered, wraps at 2^CNT_W.

Behaviour:
- Reset (reset=0, async): push=0, data_out=0, grant_idx=0, grant_cnt=0, rr_ptr=0, state=IDLE; pop=0 because it is gated by state.
- States:
  - IDLE: active=0; no grants. active=1 -> RUN on the next edge.
  - RUN: grants allowed. active=0 -> IDLE. No eligible input -> STALL.
  - STALL: at least one input is non-empty but every such input is blocked (or none pending). Any eligible input -> RUN. active=0 -> IDLE.
  - The state register only gates grants; grant logic evaluates eligibility every cycle while the state is RUN or STALL and active=1.
- Eligibility: elig[i] = active & !empty_in[i] & !almost_full_out[dest(data_in[i])].
- Selection:
  - rr_mode=0: lowest i with elig[i].
  - rr_mode=1: first eligible i scanning rr_ptr, rr_ptr+1, ... mod N_CH. After a grant g, rr_ptr <= (g+1) mod N_CH. rr_ptr is unchanged without a grant and unchanged while in rr_mode=0.
- Same cycle t as the grant: pop[g]=1 (combinational).
- Edge ending cycle t: push <= one-hot(dest), data_out <= data_in[g], grant_idx <= g, grant_cnt <= grant_cnt+1.
- Latency: pop-to-push is 1 cycle.
- Cycle without a grant: push <= 0; data_out and grant_idx hold.
- Backpressure is sampled in the grant cycle, so output FIFOs must assert almost_full with at least 2 free slots.
- Simultaneous events:
  - Several inputs may target the same destination; only one wins per cycle.
  - A destination turning almost-full in the same cycle blocks that cycle's grant.
  - An in-flight push (granted in the previous cycle) always completes.
- active falling: no pop in that same cycle; a pending push still completes next cycle.
- Reset mid-operation: push is cleared immediately; a word popped in the reset cycle is lost. This is an accepted system-level constraint.
- X-safety: pop stays 0 when empty_in is all ones, regardless of data_in.

Decomposition:
- Package arbitro_pkg holds:
  - state encoding enum {IDLE, RUN, STALL};
  - function dest_of(word) that extracts the destination field;
  - localparam defaults for N_CH and DATA_W.
- One sub-module, rr_select: combinational N_CH-wide round-robin/priority picker with inputs req, ptr, mode and outputs grant_onehot, grant_valid, grant_bin.

Test Plan:
- Reset, then active=1, empty_in=4'b1111 for 5 cycles -> pop=0, push=0, grant_cnt=0, state STALL.
- rr_mode=0, all four channels hold 'hABC (dest 2), empty_in=0 -> pop=4'b0001 every cycle. Next cycle push=4'b0100, data_out='hABC, grant_idx=0.
- rr_mode=1, all four channels non-empty (dest 0..3) -> pop sequence 0001, 0010, 0100, 1000, 0001. grant_cnt increments by 1 per cycle, rr_ptr wraps 3->0.
- Staircase backpressure with almost_full_out=4'b1000, then 4'b1100, then 4'b1110; words to dest 3 and then dest 2 become blocked. Blocked inputs are skipped, others keep flowing. Once all targeted destinations are blocked -> pop=0, state STALL; release returns to RUN within 1 cycle.
- Drop active while granting -> no pop in the deassert cycle; the previous grant's push is still seen once; state IDLE.
- Assert reset=0 for one cycle while pushing -> push, data_out and grant_cnt go to 0 asynchronously. After release, round-robin restarts at channel 0.

Source files
------------

// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the N-channel input-to-output FIFO arbiter.
package arbitro_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  // Destination field sits in the top dest_w bits of a data_w-bit word.
  function automatic logic [3:0] dest_of(input logic [63:0] word,
                                         input int data_w,
                                         input int dest_w);
    logic [63:0] sh;
    sh = word >> (data_w - dest_w);
    return 4'(sh & ((64'd1 << dest_w) - 64'd1));
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational picker: lowest-index or round-robin from ptr.
module rr_select #(
  parameter int N_CH = 4,
  localparam int DEST_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]   req,
  input  logic [DEST_W-1:0] ptr,
  input  logic              mode,
  output logic [N_CH-1:0]   grant_onehot,
  output logic              grant_valid,
  output logic [DEST_W-1:0] grant_bin
);

  logic [DEST_W-1:0] idx;

  // N_CH is a power of two, so the DEST_W-bit add wraps modulo N_CH.
  always_comb begin
    grant_onehot = '0;
    grant_valid  = 1'b0;
    grant_bin    = '0;
    idx          = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = mode ? ptr + DEST_W'(k) : DEST_W'(k);
      if (!grant_valid && req[idx]) begin
        grant_valid       = 1'b1;
        grant_bin         = idx;
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Arbiter moving one word per cycle from N input FIFOs to N output FIFOs,
// honouring per-destination almost-full backpressure.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16,
  localparam int DEST_W = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     active,
  input  logic                     rr_mode,
  input  logic [N_CH-1:0]          empty_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic [N_CH-1:0]          almost_full_out,
  output logic [N_CH-1:0]          pop,
  output logic [N_CH-1:0]          push,
  output logic [DATA_W-1:0]        data_out,
  output logic [DEST_W-1:0]        grant_idx,
  output logic [CNT_W-1:0]         grant_cnt
);

  state_t              state;
  logic [DEST_W-1:0]   rr_ptr;
  logic [DATA_W-1:0]   words [N_CH];
  logic [DEST_W-1:0]   dest  [N_CH];
  logic [N_CH-1:0]     elig;
  logic [N_CH-1:0]     sel_oh;
  logic                sel_vld;
  logic [DEST_W-1:0]   sel_bin;
  logic                grant_p0;
  logic [N_CH-1:0]     push_p0;

  // Stage p0: eligibility, selection and combinational pop.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      words[i] = data_in[i*DATA_W +: DATA_W];
      dest[i]  = DEST_W'(dest_of(64'(words[i]), DATA_W, DEST_W));
      elig[i]  = active & ~empty_in[i] & ~almost_full_out[dest[i]];
    end
  end

  rr_select #(.N_CH(N_CH)) u_sel (
    .req          (elig),
    .ptr          (rr_ptr),
    .mode         (rr_mode),
    .grant_onehot (sel_oh),
    .grant_valid  (sel_vld),
    .grant_bin    (sel_bin)
  );

  assign grant_p0 = sel_vld && (state != IDLE);
  assign pop      = grant_p0 ? sel_oh : '0;
  assign push_p0  = grant_p0 ? (N_CH'(1) << dest[sel_bin]) : '0;

  // Stage p1: registered push, word, grant bookkeeping and state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      push      <= '0;
      data_out  <= '0;
      grant_idx <= '0;
      grant_cnt <= '0;
    end else begin
      push <= push_p0;
      if (grant_p0) begin
        data_out  <= words[sel_bin];
        grant_idx <= sel_bin;
        grant_cnt <= grant_cnt + CNT_W'(1);
        if (rr_mode) rr_ptr <= sel_bin + DEST_W'(1);
      end
      case (state)
        IDLE:    if (active) state <= RUN;
        RUN:     if (!active) state <= IDLE;
                 else if (!sel_vld) state <= STALL;
        STALL:   if (!active) state <= IDLE;
                 else if (sel_vld) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: vector table plus hand-written corner sequences.
module tb_arbitro_rr;
  import arbitro_pkg::*;

  typedef struct packed {
    logic [3:0]  push;
    logic [11:0] data;
    logic [1:0]  idx;
  } exp_t;

  typedef struct packed {
    logic [3:0]  emp;
    logic [3:0]  af;
    logic [47:0] dw;
    logic [3:0]  pop;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        active = 1'b0;
  logic        rr_mode = 1'b0;
  logic [3:0]  empty_in = 4'hF;
  logic [3:0]  almost_full_out = 4'h0;
  logic [47:0] data_in = '0;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [11:0] data_out;
  logic [1:0]  grant_idx;
  logic [15:0] grant_cnt;

  int   checks = 0;
  int   failures = 0;
  int   cnt_m = 0;
  exp_t q[$];
  vec_t vt[9];

  always #5 clk = ~clk;

  arbitro_rr #(.N_CH(4), .DATA_W(12), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .active          (active),
    .rr_mode         (rr_mode),
    .empty_in        (empty_in),
    .data_in         (data_in),
    .almost_full_out (almost_full_out),
    .pop             (pop),
    .push            (push),
    .data_out        (data_out),
    .grant_idx       (grant_idx),
    .grant_cnt       (grant_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sample one cycle at the falling edge, then step to just after the rising edge.
  task automatic cyc(input logic [3:0] ep, input string nm);
    exp_t e;
    exp_t n;
    int   g;
    logic [11:0] w;
    @(negedge clk);
    chk({nm, " pop"}, 32'(pop), 32'(ep));
    e = (q.size() != 0) ? q.pop_front() : '0;
    chk({nm, " push"}, 32'(push), 32'(e.push));
    if (e.push != 4'b0000) begin
      chk({nm, " data_out"}, 32'(data_out), 32'(e.data));
      chk({nm, " grant_idx"}, 32'(grant_idx), 32'(e.idx));
    end
    chk({nm, " grant_cnt"}, 32'(grant_cnt), 32'(cnt_m));
    n = '0;
    if (ep != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (ep[i]) g = i;
      w = data_in[g*12 +: 12];
      n.push = 4'b0001 << w[11:10];
      n.data = w;
      n.idx  = 2'(g);
      cnt_m++;
    end
    q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // emp, af, {ch3,ch2,ch1,ch0}, expected pop (fixed priority)
    vt[0] = {4'b0000, 4'b0000, {4{12'hABC}}, 4'b0001};
    vt[1] = {4'b0000, 4'b0000, {4{12'hABC}}, 4'b0001};
    vt[2] = {4'b0001, 4'b0000, {4{12'hABC}}, 4'b0010};
    vt[3] = {4'b1110, 4'b0100, {4{12'hABC}}, 4'b0000};
    vt[4] = {4'b0000, 4'b0100, {12'hC01, 12'h456, 12'h123, 12'hABC}, 4'b0010};
    vt[5] = {4'b0000, 4'b0011, {12'hC01, 12'h456, 12'h123, 12'hABC}, 4'b0001};
    vt[6] = {4'b0000, 4'b1111, {12'hC01, 12'h456, 12'h123, 12'hABC}, 4'b0000};
    vt[7] = {4'b1111, 4'b0000, {4{12'hFFF}}, 4'b0000};
    vt[8] = {4'b0111, 4'b0000, {12'hC01, 12'h456, 12'h123, 12'hABC}, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst push", 32'(push), 32'h0);
    chk("rst data_out", 32'(data_out), 32'h0);
    chk("rst grant_idx", 32'(grant_idx), 32'h0);
    chk("rst grant_cnt", 32'(grant_cnt), 32'h0);
    chk("rst state", 32'(dut.state), 32'(IDLE));
    reset = 1'b1;

    active = 1'b1;
    empty_in = 4'hF;
    for (int k = 0; k < 5; k++) cyc(4'b0000, "all_empty");
    chk("empty state", 32'(dut.state), 32'(STALL));

    rr_mode = 1'b0;
    for (int k = 0; k < 9; k++) begin
      empty_in = vt[k].emp;
      almost_full_out = vt[k].af;
      data_in = vt[k].dw;
      cyc(vt[k].pop, $sformatf("tbl%0d", k));
    end

    rr_mode = 1'b1;
    empty_in = 4'b0000;
    almost_full_out = 4'b0000;
    data_in = {12'hC03, 12'h802, 12'h401, 12'h000};
    cyc(4'b0001, "rr0");
    cyc(4'b0010, "rr1");
    cyc(4'b0100, "rr2");
    cyc(4'b1000, "rr3");
    cyc(4'b0001, "rr_wrap");

    data_in = {12'h003, 12'h402, 12'h801, 12'hC00};
    almost_full_out = 4'b1000;
    cyc(4'b0010, "sc_a");
    cyc(4'b0100, "sc_b");
    cyc(4'b1000, "sc_c");
    cyc(4'b0010, "sc_d");
    almost_full_out = 4'b1100;
    cyc(4'b0100, "sc_e");
    cyc(4'b1000, "sc_f");
    cyc(4'b0100, "sc_g");
    almost_full_out = 4'b1110;
    cyc(4'b1000, "sc_h");
    cyc(4'b1000, "sc_i");
    almost_full_out = 4'b1111;
    cyc(4'b0000, "sc_j");
    cyc(4'b0000, "sc_k");
    chk("blocked state", 32'(dut.state), 32'(STALL));
    almost_full_out = 4'b0000;
    cyc(4'b0001, "release");
    chk("release state", 32'(dut.state), 32'(RUN));

    cyc(4'b0010, "pre_drop");
    active = 1'b0;
    cyc(4'b0000, "act_drop");
    chk("drop state", 32'(dut.state), 32'(IDLE));
    cyc(4'b0000, "act_low");

    active = 1'b1;
    cyc(4'b0000, "wake_idle");
    cyc(4'b0100, "pre_rst");
    chk("pre_rst push", 32'(push), 32'b0010);
    reset = 1'b0;
    #1;
    chk("mid_rst push", 32'(push), 32'h0);
    chk("mid_rst data_out", 32'(data_out), 32'h0);
    chk("mid_rst grant_cnt", 32'(grant_cnt), 32'h0);
    chk("mid_rst pop", 32'(pop), 32'h0);
    q.delete();
    cnt_m = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(4'b0001, "post_rst0");
    cyc(4'b0010, "post_rst1");
    cyc(4'b0100, "post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
